stream_demux_1_4: RTL and testbench

- 1-to-4 stream demultiplexer with valid/ready handshakes; the distribution counterpart of the 4:1 select mux.
- Routes each accepted upstream word to one of four downstream lanes selected by `up_sel`.
- Each lane owns a one-entry output register, giving one-cycle latency and full throughput.
- Per-lane saturating transfer counters are exposed for debug and bench checking.

---
 rtl/stream_demux_1_4.sv | 76 +++++++
 tb/tb_stream_demux_1_4.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_4.sv
// 1-to-4 valid/ready stream demultiplexer with one output register per lane and
// saturating per-lane transfer counters. Define DEMUX_RR_EN for round-robin lane selection.
module stream_demux_1_4 #(
   parameter int unsigned W     = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               up_valid,
   output logic               up_ready,
   input  logic [W-1:0]       up_data,
   input  logic [1:0]         up_sel,
   output logic [3:0]         dn_valid,
   input  logic [3:0]         dn_ready,
   output logic [4*W-1:0]     dn_data,
   output logic [4*CNT_W-1:0] dn_cnt
);

   localparam int unsigned LANES = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0] tgt;
   logic       up_fire;
   logic [3:0] wr_en;
   logic [3:0] dn_fire;

`ifdef DEMUX_RR_EN
   logic [1:0] rr_ptr;

   // Pointer moves only on an accepted word, so a stalled lane is never skipped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 2'd0;
      end else if (up_fire) begin
         rr_ptr <= rr_ptr + 2'd1;
      end
   end

   assign tgt = rr_ptr;
`else
   // Gating to lane 0 keeps an undriven up_sel from reaching up_ready while idle.
   assign tgt = up_valid ? up_sel : 2'd0;
`endif

   always_comb begin
      up_ready     = !dn_valid[tgt] || dn_ready[tgt];
      up_fire      = up_valid && up_ready;
      wr_en        = 4'b0000;
      if (up_fire) begin
         wr_en[tgt] = 1'b1;
      end
      dn_fire      = dn_valid & dn_ready;
   end

   // Lane registers: a write in the same cycle as a drain reloads without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dn_valid <= '0;
         dn_data  <= '0;
         dn_cnt   <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
               dn_valid[i]        <= 1'b1;
               dn_data[i*W +: W]  <= up_data;
            end else if (dn_fire[i]) begin
               dn_valid[i]        <= 1'b0;
            end
            if (dn_fire[i] && (dn_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
               dn_cnt[i*CNT_W +: CNT_W] <= dn_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Randomized scoreboard bench for stream_demux_1_4 with directed scenarios.
// Build with DEMUX_RR_EN defined to exercise the round-robin variant.
module tb_stream_demux_1_4;

   localparam int unsigned W     = 4;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned CMAX  = (1 << CNT_W) - 1;

   logic               clk;
   logic               rst_n;
   logic               up_valid;
   logic               up_ready;
   logic [W-1:0]       up_data;
   logic [1:0]         up_sel;
   logic [3:0]         dn_valid;
   logic [3:0]         dn_ready;
   logic [4*W-1:0]     dn_data;
   logic [4*CNT_W-1:0] dn_cnt;

   stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_data  (up_data),
      .up_sel   (up_sel),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready),
      .dn_data  (dn_data),
      .dn_cnt   (dn_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: words in flight per lane, completed transfers per lane, rr pointer.
   logic [W-1:0] q [4][$];
   int           cnt_m [4];
   logic [1:0]   rr_m;
   bit           mon_en;

   int n_tests;
   int n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] lane_data(input int i);
      return dn_data[i*W +: W];
   endfunction

   function automatic logic [CNT_W-1:0] lane_cnt(input int i);
      return dn_cnt[i*CNT_W +: CNT_W];
   endfunction

   // Monitor: compares DUT outputs with the model and retires drained words.
   initial begin
      logic [1:0] t;
      logic       exp_rdy;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en && rst_n) begin
`ifdef DEMUX_RR_EN
            t = rr_m;
`else
            t = up_valid ? up_sel : 2'd0;
`endif
            exp_rdy = (q[t].size() == 0) || dn_ready[t];
            chk("up_ready", 32'(up_ready), 32'(exp_rdy));
            for (int i = 0; i < 4; i++) begin
               chk($sformatf("lane%0d_valid", i), 32'(dn_valid[i]), 32'(q[i].size() != 0));
               chk($sformatf("lane%0d_cnt", i), 32'(lane_cnt(i)), 32'(cnt_m[i]));
               if (q[i].size() != 0) begin
                  if (dn_valid[i]) begin
                     chk($sformatf("lane%0d_data", i), 32'(lane_data(i)), 32'(q[i][0]));
                  end
                  if (dn_ready[i]) begin
                     void'(q[i].pop_front());
                     if (cnt_m[i] < int'(CMAX)) cnt_m[i]++;
                  end
               end
            end
         end
      end
   end

   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         cnt_m[i] = 0;
      end
      rr_m = 2'd0;
   endtask

   // One bus cycle: drive at the falling edge, record an accepted word before the rising edge.
   task automatic cycle(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                        input logic [3:0] r);
      logic [1:0] lane;
      @(negedge clk);
      up_valid = v;
      up_sel   = s;
      up_data  = d;
      dn_ready = r;
      #2;
      if (rst_n && up_valid && up_ready) begin
`ifdef DEMUX_RR_EN
         lane = rr_m;
`else
         lane = up_sel;
`endif
         q[lane].push_back(up_data);
         rr_m = rr_m + 2'd1;
      end
   endtask

   // Reset asserted mid-cycle; state must clear without waiting for a clock edge.
   task automatic do_reset();
      @(negedge clk);
      up_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_dn_valid", 32'(dn_valid), 32'd0);
      chk("rst_dn_cnt", 32'(dn_cnt), 32'd0);
      clear_model();
      mon_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      mon_en   = 1'b0;
      rst_n    = 1'b1;
      up_valid = 1'b0;
      up_sel   = 2'd0;
      up_data  = '0;
      dn_ready = 4'b0000;
      clear_model();

      do_reset();
      cycle(1'b0, 2'd0, 4'h0, 4'b0000);
      chk("idle_up_ready", 32'(up_ready), 32'd1);
      chk("idle_dn_valid", 32'(dn_valid), 32'd0);

`ifndef DEMUX_RR_EN
      // Single route to lane 2
      cycle(1'b1, 2'd2, 4'hA, 4'b1111);
      cycle(1'b0, 2'd0, 4'h0, 4'b1111);
      chk("route_valid", 32'(dn_valid), 32'b0100);
      chk("route_data", 32'(lane_data(2)), 32'hA);
      cycle(1'b0, 2'd0, 4'h0, 4'b1111);
      chk("route_drained", 32'(dn_valid), 32'd0);
      chk("route_cnt", 32'(lane_cnt(2)), 32'd1);

      // Back-pressure on lane 1, then pass-through reload
      cycle(1'b1, 2'd1, 4'h3, 4'b0000);
      cycle(1'b1, 2'd1, 4'h5, 4'b0000);
      chk("bp_stall", 32'(up_ready), 32'd0);
      chk("bp_hold", 32'(lane_data(1)), 32'h3);
      cycle(1'b1, 2'd1, 4'h5, 4'b0010);
      cycle(1'b0, 2'd0, 4'h0, 4'b0010);
      chk("bp_nobubble_v", 32'(dn_valid[1]), 32'd1);
      chk("bp_nobubble_d", 32'(lane_data(1)), 32'h5);
      cycle(1'b0, 2'd0, 4'h0, 4'b0000);
      chk("bp_cnt", 32'(lane_cnt(1)), 32'd2);

      // Lane 0 stalled full does not block lane 3
      cycle(1'b1, 2'd0, 4'h9, 4'b0000);
      cycle(1'b1, 2'd3, 4'h7, 4'b0000);
      chk("indep_ready", 32'(up_ready), 32'd1);
      cycle(1'b0, 2'd0, 4'h0, 4'b0000);
      chk("indep_valid", 32'(dn_valid), 32'b1001);
      chk("indep_l3", 32'(lane_data(3)), 32'h7);
      chk("indep_l0", 32'(lane_data(0)), 32'h9);
      cycle(1'b0, 2'd0, 4'h0, 4'b1111);

      // Undriven select while idle must not disturb up_ready
      cycle(1'b0, 2'bxx, 4'h0, 4'b0000);
      chk("xsel_ready", 32'(up_ready), 32'd1);

      // Counter saturation on lane 0
      for (int k = 0; k < 5; k++) cycle(1'b1, 2'd0, W'(k), 4'b1111);
      cycle(1'b0, 2'd0, 4'h0, 4'b1111);
      cycle(1'b0, 2'd0, 4'h0, 4'b0000);
      chk("sat_cnt", 32'(lane_cnt(0)), 32'(CMAX));

      // Lanes 0 and 2 full, then asynchronous reset
      cycle(1'b1, 2'd0, 4'h1, 4'b0000);
      cycle(1'b1, 2'd2, 4'h2, 4'b0000);
      cycle(1'b0, 2'd0, 4'h0, 4'b0000);
      chk("preflush_valid", 32'(dn_valid), 32'b0101);
      do_reset();
`else
      // Fill all lanes in order; a full target must block without skipping
      for (int k = 0; k < 4; k++) cycle(1'b1, 2'(3 - k), W'(k + 1), 4'b0000);
      cycle(1'b1, 2'd1, 4'hE, 4'b0000);
      chk("rr_full_valid", 32'(dn_valid), 32'hF);
      chk("rr_block", 32'(up_ready), 32'd0);
      for (int k = 0; k < 4; k++) chk($sformatf("rr_l%0d", k), 32'(lane_data(k)), 32'(k + 1));
      do_reset();
      // Five transfers after reset land on lanes 0,1,2,3,0
      for (int k = 0; k < 5; k++) cycle(1'b1, 2'd3, W'(k + 8), 4'b1111);
      cycle(1'b0, 2'd0, 4'h0, 4'b1111);
      cycle(1'b0, 2'd0, 4'h0, 4'b0000);
      chk("rr_cnt0", 32'(lane_cnt(0)), 32'd2);
      chk("rr_cnt3", 32'(lane_cnt(3)), 32'd1);
`endif

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom), 4'($urandom));
      end
      do_reset();
      for (int n = 0; n < 1000; n++) begin
         cycle(1'($urandom_range(0, 1)), 2'($urandom), W'($urandom),
               4'($urandom) | 4'($urandom));
      end
      cycle(1'b0, 2'd0, 4'h0, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
